// File: rtl/bus_probe.sv
// Debug bus probe: a programmable pattern driver for the shared datapath bus,
// plus a circular trace buffer that captures bus values and plays them back in order.
module bus_probe #(
  parameter int              WIDTH         = 16,
  parameter int              TRACE_DEPTH   = 8,
  parameter logic [WIDTH-1:0] RESET_PATTERN = 16'h5500,
  parameter int              LED_WIDTH     = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           drive_en,
  input  logic [1:0]                     mode,
  input  logic                           load,
  input  logic [WIDTH-1:0]               load_val,
  output logic [WIDTH-1:0]               bus_out,
  output logic                           bus_oe,
  input  logic [WIDTH-1:0]               bus_in,
  input  logic                           capture,
  input  logic                           trace_rd,
  output logic [WIDTH-1:0]               trace_data,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic                           trace_empty,
  output logic                           trace_full,
  output logic                           overflow,
  output logic [LED_WIDTH-1:0]           led
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(TRACE_DEPTH);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_INC  = 2'b01,
    MODE_DEC  = 2'b10,
    MODE_ROTL = 2'b11
  } mode_e;

  logic [WIDTH-1:0] drv;
  logic [WIDTH-1:0] mem [TRACE_DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             pop;
  logic             overwrite;

  // ---------------------------------------------------------------------------
  // Pattern driver
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      drv <= RESET_PATTERN;
    end else if (load) begin
      drv <= load_val;
    end else if (drive_en) begin
      unique case (mode_e'(mode))
        MODE_HOLD: drv <= drv;
        MODE_INC:  drv <= drv + WIDTH'(1);
        MODE_DEC:  drv <= drv - WIDTH'(1);
        MODE_ROTL: drv <= {drv[WIDTH-2:0], drv[WIDTH-1]};
      endcase
    end
  end

  assign bus_out = drv;
  assign bus_oe  = drive_en;

  // ---------------------------------------------------------------------------
  // Trace buffer
  // ---------------------------------------------------------------------------
  assign trace_empty = (count == '0);
  assign trace_full  = (count == FULL_COUNT);
  assign trace_count = count;

  // A read on an empty buffer is dropped; a capture into a full buffer with no
  // read pushes the oldest entry out to make room.
  assign pop       = trace_rd && !trace_empty;
  assign overwrite = capture && !trace_rd && trace_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture) begin
        wptr <= wptr + AW'(1);
      end
      if (pop || overwrite) begin
        rptr <= rptr + AW'(1);
      end
      if (capture && !pop && !trace_full) begin
        count <= count + CW'(1);
      end else if (!capture && pop) begin
        count <= count - CW'(1);
      end
      if (overwrite) begin
        overflow <= 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; entries are only visible through
  // rptr while count is non-zero, so stale contents after reset are harmless.
  always_ff @(posedge clk) begin
    if (capture && !reset) begin
      mem[wptr] <= bus_in;
    end
  end

  assign trace_data = trace_empty ? '0 : mem[rptr];

  assign led = {overflow, drv[LED_WIDTH-2:0]};

endmodule

// File: tb/tb_bus_probe.sv
// Directed bench for bus_probe: driver step modes, load priority, trace buffer
// overflow/drain/simultaneous ops, capture while driving, and mid-run reset.
module tb_bus_probe;

  logic        clk = 1'b0;
  logic        reset;
  logic        drive_en;
  logic [1:0]  mode;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic [15:0] bus_in;
  logic [15:0] bus_ext;
  logic        capture;
  logic        trace_rd;
  logic [15:0] trace_data;
  logic [3:0]  trace_count;
  logic        trace_empty;
  logic        trace_full;
  logic        overflow;
  logic [4:0]  led;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Top-level tri-state: the probe's value wins whenever it owns the bus.
  assign bus_in = bus_oe ? bus_out : bus_ext;

  bus_probe dut (
    .clk         (clk),
    .reset       (reset),
    .drive_en    (drive_en),
    .mode        (mode),
    .load        (load),
    .load_val    (load_val),
    .bus_out     (bus_out),
    .bus_oe      (bus_oe),
    .bus_in      (bus_in),
    .capture     (capture),
    .trace_rd    (trace_rd),
    .trace_data  (trace_data),
    .trace_count (trace_count),
    .trace_empty (trace_empty),
    .trace_full  (trace_full),
    .overflow    (overflow),
    .led         (led)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; drive_en = 1'b0; mode = 2'b00; load = 1'b0;
    load_val = 16'h0; capture = 1'b0; trace_rd = 1'b0; bus_ext = 16'h0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (bus_out !== 16'h5500) begin tests_failed++; $display("FAIL reset_bus_out: got %h want 5500", bus_out); end
    tests_run++; if (trace_count !== 4'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", trace_count); end
    tests_run++; if (trace_empty !== 1'b1 || trace_full !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: empty %b full %b want 1 0", trace_empty, trace_full); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    tests_run++; if (trace_data !== 16'h0) begin tests_failed++; $display("FAIL reset_trace_data: got %h want 0000", trace_data); end
    tests_run++; if (led !== 5'h00) begin tests_failed++; $display("FAIL reset_led: got %h want 00", led); end
  endtask

  task automatic test_step();
    logic [15:0] exp_inc [3] = '{16'h5501, 16'h5502, 16'h5503};
    drive_en = 1'b1; mode = 2'b01;
    #1;
    tests_run++; if (bus_oe !== 1'b1) begin tests_failed++; $display("FAIL step_oe_on: got %b want 1", bus_oe); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (bus_out !== exp_inc[i]) begin tests_failed++; $display("FAIL step_inc_%0d: got %h want %h", i, bus_out, exp_inc[i]); end
    end
    drive_en = 1'b0;
    #1;
    tests_run++; if (bus_oe !== 1'b0) begin tests_failed++; $display("FAIL step_oe_off: got %b want 0", bus_oe); end
    tick();
    tests_run++; if (bus_out !== 16'h5503) begin tests_failed++; $display("FAIL step_hold_idle: got %h want 5503", bus_out); end
  endtask

  task automatic test_load_modes();
    load = 1'b1; load_val = 16'hFFFF;
    tick();
    tests_run++; if (bus_out !== 16'hFFFF) begin tests_failed++; $display("FAIL load_ffff: got %h want ffff", bus_out); end
    load = 1'b0; drive_en = 1'b1; mode = 2'b01;
    tick();
    tests_run++; if (bus_out !== 16'h0000) begin tests_failed++; $display("FAIL inc_wrap: got %h want 0000", bus_out); end
    mode = 2'b10;
    tick();
    tests_run++; if (bus_out !== 16'hFFFF) begin tests_failed++; $display("FAIL dec_wrap: got %h want ffff", bus_out); end
    mode = 2'b00;
    tick();
    tests_run++; if (bus_out !== 16'hFFFF) begin tests_failed++; $display("FAIL hold_mode: got %h want ffff", bus_out); end
    drive_en = 1'b0; load = 1'b1; load_val = 16'h8001;
    tick();
    load = 1'b0; drive_en = 1'b1; mode = 2'b11;
    tick();
    tests_run++; if (bus_out !== 16'h0003) begin tests_failed++; $display("FAIL rotl: got %h want 0003", bus_out); end
    load = 1'b1; load_val = 16'h1234; mode = 2'b01;
    tick();
    tests_run++; if (bus_out !== 16'h1234) begin tests_failed++; $display("FAIL load_priority: got %h want 1234", bus_out); end
    tests_run++; if (led !== 5'h04) begin tests_failed++; $display("FAIL led_pattern: got %h want 04", led); end
    idle();
  endtask

  task automatic test_overflow();
    capture = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_ext = 16'h00A0 + 16'(i);
      tick();
    end
    capture = 1'b0;
    tests_run++; if (trace_full !== 1'b1 || trace_count !== 4'd8) begin tests_failed++; $display("FAIL fill_full: full %b count %0d want 1 8", trace_full, trace_count); end
    tests_run++; if (trace_data !== 16'h00A0) begin tests_failed++; $display("FAIL fill_head: got %h want 00a0", trace_data); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fill_no_overflow: got %b want 0", overflow); end
    capture = 1'b1; bus_ext = 16'h00A8;
    tick();
    capture = 1'b0;
    tests_run++; if (trace_count !== 4'd8) begin tests_failed++; $display("FAIL ovf_count: got %0d want 8", trace_count); end
    tests_run++; if (trace_data !== 16'h00A1) begin tests_failed++; $display("FAIL ovf_head: got %h want 00a1", trace_data); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    tests_run++; if (led !== 5'h14) begin tests_failed++; $display("FAIL ovf_led: got %h want 14", led); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      tests_run++; if (trace_data !== 16'h00A1 + 16'(i)) begin tests_failed++; $display("FAIL drain_%0d: got %h want %h", i, trace_data, 16'h00A1 + 16'(i)); end
      trace_rd = 1'b1;
      tick();
      trace_rd = 1'b0;
    end
    tests_run++; if (trace_empty !== 1'b1 || trace_data !== 16'h0) begin tests_failed++; $display("FAIL drain_empty: empty %b data %h want 1 0000", trace_empty, trace_data); end
    trace_rd = 1'b1;
    tick();
    trace_rd = 1'b0;
    tests_run++; if (trace_count !== 4'd0 || trace_empty !== 1'b1) begin tests_failed++; $display("FAIL underflow_ignored: count %0d empty %b want 0 1", trace_count, trace_empty); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    capture = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_ext = 16'h00C0 + 16'(i);
      tick();
    end
    trace_rd = 1'b1; bus_ext = 16'h00B0;
    tick();
    capture = 1'b0; trace_rd = 1'b0;
    tests_run++; if (trace_count !== 4'd8) begin tests_failed++; $display("FAIL full_rw_count: got %0d want 8", trace_count); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL full_rw_overflow: got %b want 0", overflow); end
    tests_run++; if (trace_data !== 16'h00C1) begin tests_failed++; $display("FAIL full_rw_head: got %h want 00c1", trace_data); end
    trace_rd = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    trace_rd = 1'b0;
    tests_run++; if (trace_data !== 16'h00B0 || trace_count !== 4'd1) begin tests_failed++; $display("FAIL full_rw_tail: data %h count %0d want 00b0 1", trace_data, trace_count); end
    trace_rd = 1'b1;
    tick();
    capture = 1'b1; bus_ext = 16'h00D5;
    tick();
    capture = 1'b0; trace_rd = 1'b0;
    tests_run++; if (trace_count !== 4'd1 || trace_data !== 16'h00D5) begin tests_failed++; $display("FAIL empty_rw: count %0d data %h want 1 00d5", trace_count, trace_data); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_en = 1'b1; mode = 2'b01; capture = 1'b1; bus_ext = 16'hDEAD;
    tick();
    tick();
    drive_en = 1'b0; capture = 1'b0;
    tests_run++; if (bus_out !== 16'h5502 || trace_count !== 4'd2) begin tests_failed++; $display("FAIL drive_capture_state: bus %h count %0d want 5502 2", bus_out, trace_count); end
    tests_run++; if (trace_data !== 16'h5500) begin tests_failed++; $display("FAIL drive_capture_first: got %h want 5500", trace_data); end
    trace_rd = 1'b1;
    tick();
    trace_rd = 1'b0;
    tests_run++; if (trace_data !== 16'h5501) begin tests_failed++; $display("FAIL drive_capture_second: got %h want 5501", trace_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    capture = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus_ext = 16'h00E0 + 16'(i);
      tick();
    end
    capture = 1'b0; trace_rd = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    trace_rd = 1'b0; load = 1'b1; load_val = 16'h0042;
    tick();
    load = 1'b0;
    tests_run++; if (trace_count !== 4'd5 || bus_out !== 16'h0042 || overflow !== 1'b1) begin tests_failed++; $display("FAIL mid_setup: count %0d bus %h ovf %b want 5 0042 1", trace_count, bus_out, overflow); end
    reset = 1'b1; capture = 1'b1; trace_rd = 1'b1; load = 1'b1; load_val = 16'h7777;
    drive_en = 1'b1; mode = 2'b01;
    tick();
    idle();
    tests_run++; if (trace_count !== 4'd0 || trace_empty !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_count: count %0d empty %b want 0 1", trace_count, trace_empty); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_overflow: got %b want 0", overflow); end
    tests_run++; if (bus_out !== 16'h5500) begin tests_failed++; $display("FAIL mid_reset_bus: got %h want 5500", bus_out); end
    tests_run++; if (trace_data !== 16'h0) begin tests_failed++; $display("FAIL mid_reset_data: got %h want 0000", trace_data); end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_step();
    test_load_modes();
    test_overflow();
    test_drain();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_probe.md
Name: bus_probe

Overview:
- Parametrised successor to the top-level debug bus driver and debug register.
- Drives a programmable test pattern onto the shared datapath bus, with selectable step modes and a direct load.
- Captures bus values into a circular trace buffer that is read back in order.
- Sits beside the GPR/IR/MAR/MDR/Y blocks on the bus. The top level owns the tri-state: bus = bus_oe ? bus_out : Z.

Parameters:
WIDTH, 16, bus/data width in bits.
TRACE_DEPTH, 8, trace buffer entries; power of two, >= 2.
RESET_PATTERN, 16'h5500, driver register value after reset; truncated to WIDTH.
LED_WIDTH, 5, LED output width; must be <= WIDTH.

Ports:
clk  input  1  the single-step clock (one_shot_clock at top level)
reset  input  1  synchronous, active-high
drive_en  input  1  probe owns the bus this cycle; driver steps per mode
mode  input  2  00 HOLD, 01 INC, 10 DEC, 11 ROTL
load  input  1  load load_val into driver register
load_val  input  WIDTH  value for load
bus_out  output  WIDTH  driver register contents
bus_oe  output  1  output enable for the bus tri-state
bus_in  input  WIDTH  bus value, sampled on capture
capture  input  1  push bus_in into trace buffer
trace_rd  input  1  pop oldest trace entry
trace_data  output  WIDTH  oldest entry (show-ahead); 0 when empty
trace_count  output  clog2(TRACE_DEPTH)+1  entries held
trace_empty  output  1  trace_count == 0
trace_full  output  1  trace_count == TRACE_DEPTH
overflow  output  1  sticky flag: an entry was overwritten
led  output  LED_WIDTH  {overflow, drv[LED_WIDTH-2:0]}

Behaviour:
Reset (synchronous, active-high):
- drv = RESET_PATTERN.
- Write and read pointers = 0; trace_count = 0; overflow = 0.
- Trace buffer contents are not cleared; they are unobservable while empty.
- Reset wins over every other input in the same cycle.
- Reset mid-operation discards all trace state on that edge.

Outputs:
- bus_oe = drive_en, combinational, no latency.
- bus_out = drv at all times, registered.

Driver register, per rising clk:
- If load: drv <= load_val. load has priority over stepping, regardless of drive_en.
- Else if drive_en:
  - HOLD: unchanged.
  - INC: drv+1, mod 2^WIDTH; all-ones wraps to 0.
  - DEC: drv-1; 0 wraps to all-ones.
  - ROTL: {drv[WIDTH-2:0], drv[WIDTH-1]}.
- Else: unchanged.

Trace buffer (circular FIFO):
- capture alone:
  - Not full: write bus_in at wptr; wptr++; count++.
  - Full: write at wptr (the oldest slot); wptr++; rptr++; count stays TRACE_DEPTH; overflow <= 1.
- trace_rd alone:
  - Not empty: rptr++; count--.
  - Empty: ignored, no state change.
- capture and trace_rd together:
  - Not empty: pop oldest and write new; count unchanged; no overflow, including when full.
  - Empty: write only; count = 1.
- Pointers wrap modulo TRACE_DEPTH.
- Same-cycle capture sees pre-edge bus_in. When the probe is driving, that value is the current drv, before this edge's step.
- trace_data = mem[rptr], combinational from registered state; forced to 0 when empty.
- overflow clears only on reset.

Latency: every registered output updates on the edge where its command is sampled. No multi-cycle operations, no stalls.

Test Plan:
- Reset, then drive_en=1 with mode=INC for 3 edges -> bus_out 5500, 5501, 5502, 5503; bus_oe=1. Drop drive_en -> bus_oe=0, bus_out holds 5503.
- load_val=FFFF with load=1, then INC for 1 edge -> FFFF then 0000. DEC from 0000 -> FFFF. ROTL from 8001 -> 0003. load and drive_en together in INC with load_val=1234 -> 1234, not an increment.
- capture 8 values A0..A7 -> trace_full=1, count=8, trace_data=A0, overflow=0. Capture A8 -> count=8, trace_data=A1, overflow=1, led[4]=1.
- Pop all 8 after the overflow -> data A1..A8 in order; then empty=1, trace_data=0. Extra trace_rd -> count stays 0.
- Full buffer with capture+trace_rd for 1 edge (new value B0) -> count=8, overflow unchanged, head advances. Empty buffer with capture+trace_rd -> count=1, trace_data = captured value.
- Assert reset mid-sequence with count=5 and drv=0042 -> next edge: count=0, empty=1, overflow=0, bus_out=5500.
